gate_vector_seq: RTL and testbench

GATE_VECTOR_SEQ -- requirements
Module: gate_vector_seq

---
 rtl/gate_seq_pkg.sv | 16 +
 rtl/gate_ref_model.sv | 23 ++
 rtl/gate_vector_seq.sv | 118 +++++++++++
 tb/tb_gate_vector_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// Shared types for the gate vector sequencer: FSM states and op encodings.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference: the response a healthy gate of type op gives for input p.
module gate_ref_model
    import gate_seq_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [1:0]   op,
    input  logic [N-1:0] p,
    output logic         expected
);

    always_comb begin
        expected = 1'b0;
        case (op)
            OP_NOT:  expected = ~p[0];
            OP_AND:  expected = &p;
            OP_OR:   expected = |p;
            OP_XOR:  expected = ^p;
            default: expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_vector_seq.sv
// Walks every input vector of a combinational gate and counts mismatches against a reference.
// Optional macro GATE_SEQ_STOP_ON_ERR_EN ends the run at the first mismatching vector.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; done/pass from last run visible
// ST_APPLY  | p driven, settle timer counting down to 1
// ST_SAMPLE | one cycle: vec_valid/mis valid, err_cnt update, next vector
// ST_DONE   | run finished; done pulse and pass are registered here
module gate_vector_seq
    import gate_seq_pkg::*;
#(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    output logic [N-1:0] p,
    input  logic         s,
    output logic         busy,
    output logic         vec_valid,
    output logic         mis,
    output logic [N:0]   err_cnt,
    output logic         done,
    output logic         pass
);

    localparam logic [N-1:0] P_MAX      = '1;
    localparam logic [N-1:0] P_ONE      = 1;
    localparam logic [N:0]   ERR_ONE    = 1;
    localparam logic [3:0]   TIMER_LOAD = 4'(SETTLE);
    localparam logic [3:0]   TIMER_ONE  = 4'd1;

    state_t     state;
    logic [3:0] timer;
    logic [1:0] op_q;
    logic       exp_bit;
    logic       last_vec;

    gate_ref_model #(.N(N)) u_ref (
        .op       (op_q),
        .p        (p),
        .expected (exp_bit)
    );

    // mis is registered during SAMPLE, so the stop decision looks at it directly
`ifdef GATE_SEQ_STOP_ON_ERR_EN
    assign last_vec = (p == P_MAX) || mis;
`else
    assign last_vec = (p == P_MAX);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            p         <= '0;
            busy      <= 1'b0;
            vec_valid <= 1'b0;
            mis       <= 1'b0;
            err_cnt   <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timer     <= '0;
            op_q      <= OP_NOT;
        end else begin
            vec_valid <= 1'b0;
            mis       <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_APPLY;
                        busy    <= 1'b1;
                        p       <= '0;
                        err_cnt <= '0;
                        pass    <= 1'b0;
                        op_q    <= op;
                        timer   <= TIMER_LOAD;
                    end
                end
                ST_APPLY: begin
                    timer <= timer - TIMER_ONE;
                    // s has settled for SETTLE cycles; capture the comparison on entry to SAMPLE
                    if (timer == TIMER_ONE) begin
                        state     <= ST_SAMPLE;
                        vec_valid <= 1'b1;
                        mis       <= s ^ exp_bit;
                    end
                end
                ST_SAMPLE: begin
                    if (mis) begin
                        err_cnt <= err_cnt + ERR_ONE;
                    end
                    if (last_vec) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_APPLY;
                        p     <= p + P_ONE;
                        timer <= TIMER_LOAD;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_cnt == '0);
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_seq.sv
// Directed bench for gate_vector_seq: two instances (N=1/SETTLE=1 and N=2/SETTLE=2).
module tb_gate_vector_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       go;
    int         sel;
    logic [1:0] opv;
    int         mode1, mode3;

    logic       start1, start3;
    logic [0:0] p1;
    logic [1:0] p3;
    logic       s1, s3;
    logic       busy1, vv1, mis1, done1, pass1;
    logic       busy3, vv3, mis3, done3, pass3;
    logic [1:0] err1;
    logic [2:0] err3;

    logic m_busy, m_vv, m_mis, m_done, m_pass;
    int   m_p, m_err;

    int checks = 0;
    int errors = 0;

    gate_vector_seq #(.N(1), .SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(opv), .p(p1), .s(s1),
        .busy(busy1), .vec_valid(vv1), .mis(mis1), .err_cnt(err1), .done(done1), .pass(pass1)
    );

    gate_vector_seq #(.N(2), .SETTLE(2)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .op(opv), .p(p3), .s(s3),
        .busy(busy3), .vec_valid(vv3), .mis(mis3), .err_cnt(err3), .done(done3), .pass(pass3)
    );

    // Gate under test: mode 0 is a real gate (NOT for u1, AND for u3), mode 1 is output stuck at 0
    always_comb s1 = (mode1 == 0) ? ~p1[0] : 1'b0;
    always_comb s3 = (mode3 == 0) ? &p3 : 1'b0;

    always_comb begin
        start1 = go && (sel == 1);
        start3 = go && (sel == 3);
    end

    always_comb begin
        if (sel == 1) begin
            m_busy = busy1; m_vv = vv1; m_mis = mis1; m_done = done1; m_pass = pass1;
            m_p = int'(p1); m_err = int'(err1);
        end else begin
            m_busy = busy3; m_vv = vv3; m_mis = mis3; m_done = done3; m_pass = pass3;
            m_p = int'(p3); m_err = int'(err3);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, int'(m_busy), 0);
        chk({tag, "_vv"},   int'(m_vv),   0);
        chk({tag, "_mis"},  int'(m_mis),  0);
        chk({tag, "_done"}, int'(m_done), 0);
        chk({tag, "_pass"}, int'(m_pass), 0);
        chk({tag, "_p"},    m_p,          0);
        chk({tag, "_err"},  m_err,        0);
    endtask

    // Starts a run and counts cycles from the accept edge to the done pulse.
    task automatic run(input int which, input logic [1:0] op_in, input int ga, input int gb,
                       output int cyc, output int vvc, output int mmask);
        sel = which; opv = op_in; cyc = 0; vvc = 0; mmask = 0;
        @(negedge clk); go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
        chk("accept_busy", int'(m_busy), 1);
        chk("accept_p",    m_p,          0);
        chk("accept_err",  m_err,        0);
        while (cyc < 64) begin
            go = (cyc == ga) || (cyc == gb);
            @(posedge clk); #1;
            cyc++;
            if (m_vv) begin
                vvc++;
                if (m_mis) mmask |= (1 << m_p);
            end
            if (m_done) break;
        end
        go = 1'b0;
        chk("done_seen", int'(m_done), 1);
    endtask

    int cyc, vvc, mmask;
    logic saw_done;

    initial begin
        rst_n = 1'b0; go = 1'b0; sel = 1; opv = 2'b00; mode1 = 0; mode3 = 0;
        saw_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sel = 1; chk_idle("rst_u1");
        sel = 3; chk_idle("rst_u3");
        @(negedge clk); rst_n = 1'b1;

        // N=1 NOT gate, correct
        mode1 = 0;
        run(1, 2'b00, -1, -1, cyc, vvc, mmask);
        chk("not_cycles", cyc, 5);
        chk("not_vv",     vvc, 2);
        chk("not_mask",   mmask, 0);
        chk("not_err",    m_err, 0);
        chk("not_pass",   int'(m_pass), 1);
        chk("not_busy",   int'(m_busy), 0);
        @(posedge clk); #1;
        chk("not_done_pulse", int'(m_done), 0);
        chk("not_pass_hold",  int'(m_pass), 1);

        // N=1 NOT expected, output stuck at 0: only p=0 mismatches
        mode1 = 1;
        run(1, 2'b00, -1, -1, cyc, vvc, mmask);
        chk("stuck_cycles", cyc, 5);
        chk("stuck_mask",   mmask, 1);
        chk("stuck_err",    m_err, 1);
        chk("stuck_pass",   int'(m_pass), 0);

        // start pulsed during APPLY (cycle 1) and DONE (cycle 5) is ignored
        mode1 = 0;
        run(1, 2'b00, 0, 4, cyc, vvc, mmask);
        chk("ign_cycles", cyc, 5);
        chk("ign_vv",     vvc, 2);
        chk("ign_err",    m_err, 0);
        chk("ign_pass",   int'(m_pass), 1);
        @(posedge clk); #1;
        chk("ign_no_restart", int'(m_busy), 0);

        // N=2 SETTLE=2: reset while p=10 is applied
        sel = 3; mode3 = 0; opv = 2'b11;
        @(negedge clk); go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_p == 2) break;
            @(posedge clk); #1;
        end
        chk("mid_p_reached", m_p, 2);
        #2 rst_n = 1'b0;
        #1 chk_idle("async_rst");
        @(posedge clk); #1;
        chk_idle("rst_edge");
        for (int i = 0; i < 3; i++) begin
            if (m_done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        chk("rst_no_done", int'(saw_done), 0);
        @(negedge clk); rst_n = 1'b1;

        // XOR expected, AND gate fitted: 01,10,11 mismatch (clean restart from p=00)
        mode3 = 0;
        run(3, 2'b11, -1, -1, cyc, vvc, mmask);
        chk("xor_cycles", cyc, 13);
        chk("xor_vv",     vvc, 4);
        chk("xor_mask",   mmask, 14);
        chk("xor_err",    m_err, 3);
        chk("xor_pass",   int'(m_pass), 0);
        chk("xor_p_hold", m_p, 3);

        // OR expected, output stuck at 0
        mode3 = 1;
        run(3, 2'b10, -1, -1, cyc, vvc, mmask);
`ifdef GATE_SEQ_STOP_ON_ERR_EN
        chk("or_cycles", cyc, 7);
        chk("or_vv",     vvc, 2);
        chk("or_mask",   mmask, 2);
        chk("or_p",      m_p, 1);
        chk("or_err",    m_err, 1);
`else
        chk("or_cycles", cyc, 13);
        chk("or_vv",     vvc, 4);
        chk("or_mask",   mmask, 14);
        chk("or_p",      m_p, 3);
        chk("or_err",    m_err, 3);
`endif
        chk("or_pass", int'(m_pass), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
